// File: rtl/program_assembler.sv
// program_assembler
// Packs front-panel fields into an instruction word. Each qualified button
// press becomes one registered write into the program instruction RAM.
//
// Ports:
//   clk      : system clock; all state changes on the rising edge
//   rst      : synchronous active-high reset
//   prog     : programming mode enable; presses are ignored when low
//   clear    : synchronous program restart (count/address to 0, flags cleared)
//   value    : immediate field
//   dest     : destination register field
//   src      : source register field
//   asm_op   : opcode request lines; the highest set index wins
//   wr_en    : one-cycle RAM write strobe
//   wr_addr  : RAM write address
//   wr_data  : assembled instruction
//   count    : number of instructions stored, 0..DEPTH
//   full     : count == DEPTH
//   overflow : sticky; a press was dropped while full
//
// Write interface: wr_en is a strobe with no back-pressure. The RAM must
// accept wr_addr/wr_data in every cycle where wr_en is 1. wr_addr and
// wr_data hold their previous values while wr_en is 0.
//
// Instruction layout (LSB first): value, 4-bit dest slot, 4-bit src slot,
// 8-bit opcode slot. All slots are zero-extended.
module program_assembler #(
  parameter int VALUE_W = 16,
  parameter int REG_W   = 2,
  parameter int NUM_OPS = 8,
  parameter int ADDR_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prog,
  input  logic                 clear,
  input  logic [VALUE_W-1:0]   value,
  input  logic [REG_W-1:0]     dest,
  input  logic [REG_W-1:0]     src,
  input  logic [NUM_OPS-1:0]   asm_op,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [VALUE_W+15:0]  wr_data,
  output logic [ADDR_W:0]      count,
  output logic                 full,
  output logic                 overflow
);

  localparam int INST_W = VALUE_W + 16;
  localparam int OPC_W  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  // DEPTH = 2**ADDR_W, expressed at the width of count.
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  logic              any;
  logic              any_d;
  logic              press;
  logic [OPC_W-1:0]  opc;
  logic [INST_W-1:0] inst;

  // Priority encoder: the later (higher-index) match overrides earlier ones.
  always_comb begin
    opc = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (asm_op[i]) opc = OPC_W'(i);
    end
  end

  always_comb begin
    inst = '0;
    inst[VALUE_W-1:0]           = value;
    inst[VALUE_W +: REG_W]      = dest;
    inst[VALUE_W + 4 +: REG_W]  = src;
    inst[VALUE_W + 8 +: OPC_W]  = opc;
  end

  assign any = |asm_op;
  // Rising edge of "any line held": holding a button, or adding more lines
  // while one is held, never produces a second press.
  assign press = prog & any & ~any_d;
  assign full  = (count == DEPTH_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      any_d    <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // Press history tracks the lines unconditionally, so raising prog or
      // releasing clear while a button is held does not create a press.
      any_d <= any;
      wr_en <= 1'b0;
      if (clear) begin
        count    <= '0;
        overflow <= 1'b0;
      end else if (press) begin
        if (!full) begin
          wr_en   <= 1'b1;
          wr_addr <= count[ADDR_W-1:0];
          wr_data <= inst;
          count   <= count + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_program_assembler.sv
// tb_program_assembler
// Directed bench for program_assembler (ADDR_W=2, so DEPTH=4). Expected
// writes are pushed to exp_q when a press is driven and popped by a
// monitor when the DUT strobes wr_en.
module tb_program_assembler;

  localparam int VW = 16;
  localparam int RW = 2;
  localparam int NO = 8;
  localparam int AW = 2;
  localparam int IW = VW + 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog;
  logic          clear;
  logic [VW-1:0] value;
  logic [RW-1:0] dest;
  logic [RW-1:0] src;
  logic [NO-1:0] asm_op;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] wr_data;
  logic [AW:0]   count;
  logic          full;
  logic          overflow;

  program_assembler #(
    .VALUE_W (VW),
    .REG_W   (RW),
    .NUM_OPS (NO),
    .ADDR_W  (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .prog     (prog),
    .clear    (clear),
    .value    (value),
    .dest     (dest),
    .src      (src),
    .asm_op   (asm_op),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .count    (count),
    .full     (full),
    .overflow (overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   exp_count = 0;
  logic exp_ovf = 1'b0;
  logic [AW+IW-1:0] exp_q[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void chk(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [IW-1:0] model_inst(input logic [VW-1:0] v,
                                               input logic [RW-1:0] d,
                                               input logic [RW-1:0] s,
                                               input logic [NO-1:0] op);
    logic [7:0] opc;
    opc = 8'd0;
    for (int i = NO - 1; i >= 0; i--) begin
      if (op[i]) begin
        opc = 8'(i);
        break;
      end
    end
    return {opc, 4'(s), 4'(d), v};
  endfunction

  function automatic void expect_press();
    if (prog && !clear) begin
      if (exp_count < DEPTH) begin
        exp_q.push_back({AW'(exp_count), model_inst(value, dest, src, asm_op)});
        exp_count++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (wr_en) begin
      logic [AW+IW-1:0] e;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed=addr %0h data %0h expected=none",
               wr_addr, wr_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e[AW+IW-1:IW]));
        chk("wr_data", 64'(wr_data), 64'(e[IW-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_fields(input logic [VW-1:0] v, input logic [RW-1:0] d,
                            input logic [RW-1:0] s);
    value = v;
    dest  = d;
    src   = s;
  endtask

  // Raise asm_op (from 0), hold for 'hold' cycles, release, let it settle.
  task automatic press(input logic [NO-1:0] op, input int hold);
    asm_op = op;
    expect_press();
    tick(hold);
    asm_op = '0;
    tick(2);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    exp_count = 0;
    exp_ovf   = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 64'(count), 64'(exp_count));
    chk({tag, "_full"}, 64'(full), 64'(exp_count == DEPTH));
    chk({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; prog = 1'b0; clear = 1'b0; asm_op = '0;
    set_fields('0, '0, '0);
    tick(2);
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    check_state("rst");
    rst = 1'b0;
    tick(1);

    // 1: held button gives one write
    prog = 1'b1;
    set_fields(16'h1234, 2'd2, 2'd1);
    press(8'h01, 3);
    chk("t1_data_const", 64'(wr_data), 64'h0012_1234);
    chk("t1_addr_const", 64'(wr_addr), 64'(0));
    chk("t1_wr_en_idle", 64'(wr_en), 64'(0));
    check_state("t1");

    // 2: two lines together -> one press, highest opcode
    do_clear();
    set_fields('0, '0, '0);
    press(8'h81, 2);
    chk("t2_data_const", 64'(wr_data), 64'h0700_0000);
    check_state("t2");

    // 3: presses with prog low are ignored
    do_clear();
    prog = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_fields(16'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)));
      press(NO'($urandom_range(1, 255)), 1);
    end
    prog = 1'b1;
    set_fields(16'hBEEF, 2'd3, 2'd0);
    press(8'h10, 1);
    chk("t3_addr_const", 64'(wr_addr), 64'(0));
    check_state("t3");

    // 4: fill, overflow, clear, restart
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      set_fields(16'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)));
      press(NO'($urandom_range(1, 255)), $urandom_range(1, 3));
    end
    chk("t4_full_const", 64'(full), 64'(1));
    check_state("t4_full");
    set_fields(16'h5555, 2'd1, 2'd1);
    press(8'h02, 1);
    chk("t4_ovf_const", 64'(overflow), 64'(1));
    check_state("t4_ovf");
    do_clear();
    chk("t4_clear_wr_en", 64'(wr_en), 64'(0));
    check_state("t4_clear");
    set_fields(16'hA5A5, 2'd2, 2'd3);
    press(8'h40, 1);
    check_state("t4_restart");

    // 5: press coinciding with clear is discarded; held line stays quiet
    asm_op = 8'h04;
    clear  = 1'b1;
    tick(1);
    clear = 1'b0;
    exp_count = 0;
    exp_ovf   = 1'b0;
    tick(3);
    check_state("t5_held");
    asm_op = '0;
    tick(1);
    press(8'h04, 1);
    check_state("t5_repress");

    // 6: reset one edge after a press drops the in-flight state
    do_clear();
    set_fields(16'h0F0F, 2'd1, 2'd2);
    asm_op = 8'h08;
    expect_press();
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    asm_op = '0;
    exp_count = 0;
    exp_ovf   = 1'b0;
    chk("t6_wr_en", 64'(wr_en), 64'(0));
    chk("t6_wr_data", 64'(wr_data), 64'(0));
    check_state("t6");
    tick(2);

    chk("pending_writes", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
